// File: rtl/eth_ll_pkg.sv
// Shared types for the 8-bit LocalLink to 32-bit word packer and its FIFO.
package eth_ll_pkg;

  localparam int FLAG_SOF = 0;
  localparam int FLAG_EOF = 1;
  localparam int FLAG_ERR = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;
    logic [2:0]  occ;
  } ll_word_t;

  localparam int WORD_W = $bits(ll_word_t);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } ll_state_t;

  function automatic logic [3:0] mk_flags(input logic sof, input logic eof, input logic err);
    return {1'b0, err, eof, sof};
  endfunction

endpackage

// File: rtl/eth_ll8_to_ll32_if.sv
// Byte-side and word-side handshake buses of the packer.
// master = surrounding system (MAC RX and packet_receiver), slave = the packer.
interface eth_ll8_to_ll32_if;
  logic [7:0]  ll_data_i;
  logic        ll_sof_i;
  logic        ll_eof_i;
  logic        ll_src_rdy_i;
  logic        ll_dst_rdy_o;
  logic [31:0] wr_data_o;
  logic [3:0]  wr_flags_o;
  logic [2:0]  wr_occ_o;
  logic        wr_src_rdy_o;
  logic        wr_dst_rdy_i;

  modport master (
    output ll_data_i, ll_sof_i, ll_eof_i, ll_src_rdy_i, wr_dst_rdy_i,
    input  ll_dst_rdy_o, wr_data_o, wr_flags_o, wr_occ_o, wr_src_rdy_o
  );

  modport slave (
    input  ll_data_i, ll_sof_i, ll_eof_i, ll_src_rdy_i, wr_dst_rdy_i,
    output ll_dst_rdy_o, wr_data_o, wr_flags_o, wr_occ_o, wr_src_rdy_o
  );
endinterface

// File: rtl/ll_fifo2.sv
// Two-entry single-clock FIFO; head is valid whenever o_count != 0.
module ll_fifo2
  import eth_ll_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eth_ll8_to_ll32.sv
// Packs MAC RX bytes into 32-bit words with SOF/EOF/ERR flags and
// buffers two words so packet_receiver back-pressure does not stall the MAC.
module eth_ll8_to_ll32
  import eth_ll_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  eth_ll8_to_ll32_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  function automatic logic [31:0] put_byte(input logic [31:0] base, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    int          sh;
    w  = base;
    sh = MSB_FIRST ? 8 * (3 - int'(idx)) : 8 * int'(idx);
    w[sh +: 8] = b;
    return w;
  endfunction

  ll_state_t        r_state, w_state_n;
  logic [1:0]       r_idx, w_idx_n;
  logic [31:0]      r_asm, w_asm_n;
  logic             r_first, w_first_n;
  logic             r_pend_vld, w_pend_vld_n;
  ll_word_t         r_pend, w_pend_n;
  logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

  logic             w_push, w_pop, w_accept, w_err_inc;
  ll_word_t         w_push_word, w_head;
  logic [1:0]       w_count;
  logic [31:0]      w_cur, w_solo;

  // A pending single-byte word blocks new bytes until it has been pushed.
  assign bus.ll_dst_rdy_o = !reset && (w_count < 2'd2) && !r_pend_vld;
  assign w_accept         = bus.ll_src_rdy_i && bus.ll_dst_rdy_o;
  assign bus.wr_src_rdy_o = (w_count != 2'd0);
  assign w_pop            = bus.wr_src_rdy_o && bus.wr_dst_rdy_i;
  assign bus.wr_data_o    = w_head.data;
  assign bus.wr_flags_o   = w_head.flags;
  assign bus.wr_occ_o     = w_head.occ;
  assign frame_cnt_o      = r_frame_cnt;
  assign err_cnt_o        = r_err_cnt;

  assign w_cur  = put_byte(r_asm, r_idx, bus.ll_data_i);
  assign w_solo = put_byte(32'd0, 2'd0, bus.ll_data_i);

  ll_fifo2 #(.W(WORD_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_data (w_push_word),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_count(w_count)
  );

  // Framing FSM: decides what to push and how the assembly register evolves.
  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_asm_n      = r_asm;
    w_first_n    = r_first;
    w_pend_vld_n = r_pend_vld;
    w_pend_n     = r_pend;
    w_push       = 1'b0;
    w_push_word  = '0;
    w_err_inc    = 1'b0;
    if (r_pend_vld) begin
      if (w_count != 2'd2 || w_pop) begin
        w_push       = 1'b1;
        w_push_word  = r_pend;
        w_pend_vld_n = 1'b0;
      end
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (!bus.ll_sof_i) begin
            w_err_inc = 1'b1;
          end else if (bus.ll_eof_i) begin
            w_push      = 1'b1;
            w_push_word = '{w_solo, mk_flags(1'b1, 1'b1, 1'b0), 3'd1};
          end else begin
            w_asm_n   = w_solo;
            w_idx_n   = 2'd1;
            w_first_n = 1'b1;
            w_state_n = IN_FRAME;
          end
        end
        IN_FRAME: begin
          if (bus.ll_sof_i) begin
            // Abort: close the old frame with whatever bytes are held.
            w_push      = 1'b1;
            w_push_word = '{r_asm, mk_flags(1'b0, 1'b1, 1'b1), {1'b0, r_idx}};
            w_err_inc   = 1'b1;
            if (bus.ll_eof_i) begin
              w_pend_vld_n = 1'b1;
              w_pend_n     = '{w_solo, mk_flags(1'b1, 1'b1, 1'b0), 3'd1};
              w_asm_n      = 32'd0;
              w_idx_n      = 2'd0;
              w_state_n    = IDLE;
            end else begin
              w_asm_n   = w_solo;
              w_idx_n   = 2'd1;
              w_first_n = 1'b1;
            end
          end else if (bus.ll_eof_i || r_idx == 2'd3) begin
            w_push      = 1'b1;
            w_push_word = '{w_cur, mk_flags(r_first, bus.ll_eof_i, 1'b0), {1'b0, r_idx} + 3'd1};
            w_asm_n     = 32'd0;
            w_idx_n     = 2'd0;
            w_first_n   = 1'b0;
            if (bus.ll_eof_i) w_state_n = IDLE;
          end else begin
            w_asm_n = w_cur;
            w_idx_n = r_idx + 2'd1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // State, assembly register, pending slot and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_asm       <= 32'd0;
      r_first     <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend      <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_asm      <= w_asm_n;
      r_first    <= w_first_n;
      r_pend_vld <= w_pend_vld_n;
      r_pend     <= w_pend_n;
      if (w_push && w_push_word.flags[FLAG_EOF]) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_err_inc) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eth_ll8_to_ll32.sv
// Self-checking bench for eth_ll8_to_ll32: reset, directed table, stall,
// randomized frames against a frame-level reference model, and mid-frame reset.
module tb_eth_ll8_to_ll32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  eth_ll8_to_ll32_if bus();
  logic [15:0] frame_cnt, err_cnt;

  eth_ll8_to_ll32 #(.CNT_W(16), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_cnt_o(frame_cnt),
    .err_cnt_o  (err_cnt)
  );

  typedef struct packed { logic [7:0] d; logic sof; logic eof; } byte_t;
  typedef struct packed { logic [31:0] d; logic [3:0] f; logic [2:0] o; } tb_word_t;

  typedef struct {
    int           nb;
    logic [127:0] d;
    logic [15:0]  sof_m;
    logic [15:0]  eof_m;
    int           nw;
    logic [159:0] wd;
    logic [19:0]  wf;
    logic [14:0]  wo;
    int           dframe;
    int           derr;
  } vec_t;

  byte_t    txq[$];
  tb_word_t rxq[$];
  tb_word_t expq[$];
  int       exp_frames = 0;
  int       exp_err    = 0;
  int       n_pass     = 0;
  int       n_total    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic tb_word_t mk(input logic [31:0] d, input logic [3:0] f, input logic [2:0] o);
    tb_word_t w;
    w.d = d; w.f = f; w.o = o;
    return w;
  endfunction

  // Reference: a frame's bytes cut into 4-byte chunks, first byte in the top lane.
  task automatic emit_frame(input logic [7:0] fb[$], input bit aborted);
    int n, nfull, rem, cnt;
    logic [31:0] w;
    logic [3:0]  f;
    n     = fb.size();
    nfull = aborted ? n / 4 : (n + 3) / 4;
    for (int k = 0; k < nfull; k++) begin
      w = 32'd0; cnt = 0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) begin
          w = w | (32'(fb[4 * k + j]) << (24 - 8 * j));
          cnt++;
        end
      f = 4'h0;
      if (k == 0) f[0] = 1'b1;
      if (!aborted && k == nfull - 1) f[1] = 1'b1;
      expq.push_back(mk(w, f, 3'(cnt)));
    end
    if (aborted) begin
      rem = n % 4; w = 32'd0;
      for (int j = 0; j < rem; j++) w = w | (32'(fb[4 * nfull + j]) << (24 - 8 * j));
      expq.push_back(mk(w, 4'h6, 3'(rem)));
    end
    exp_frames++;
  endtask

  task automatic build_expected();
    bit inf;
    logic [7:0] fb[$];
    inf = 1'b0;
    foreach (txq[i]) begin
      if (txq[i].sof) begin
        if (inf) begin
          emit_frame(fb, 1'b1);
          exp_err++;
        end
        fb.delete();
        inf = 1'b1;
      end else if (!inf) begin
        exp_err++;
        continue;
      end
      fb.push_back(txq[i].d);
      if (txq[i].eof) begin
        emit_frame(fb, 1'b0);
        inf = 1'b0;
      end
    end
  endtask

  // Drive txq with optional source gaps and sink stalls, collecting accepted words.
  task automatic run(input int gap_pct, input int stall_pct, input int hold_low,
                     output int acc_in_hold, output bit rdy_end_hold);
    int bi, cyc;
    bit holding;
    bi = 0; cyc = 0; holding = 1'b0;
    acc_in_hold = 0; rdy_end_hold = 1'b1;
    while ((bi < txq.size() || rxq.size() < expq.size()) && cyc < 4000) begin
      @(posedge clk); #1;
      if (bi < txq.size() && (holding || $urandom_range(99) >= gap_pct)) begin
        bus.ll_src_rdy_i = 1'b1;
        bus.ll_data_i    = txq[bi].d;
        bus.ll_sof_i     = txq[bi].sof;
        bus.ll_eof_i     = txq[bi].eof;
      end else begin
        bus.ll_src_rdy_i = 1'b0;
        bus.ll_data_i    = 8'($urandom);
        bus.ll_sof_i     = 1'($urandom);
        bus.ll_eof_i     = 1'($urandom);
      end
      bus.wr_dst_rdy_i = (cyc < hold_low) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      holding = bus.ll_src_rdy_i && !bus.ll_dst_rdy_o;
      if (bus.ll_src_rdy_i && bus.ll_dst_rdy_o) begin
        bi++;
        if (cyc < hold_low) acc_in_hold++;
      end
      if (cyc == hold_low - 1) rdy_end_hold = bus.ll_dst_rdy_o;
      if (bus.wr_src_rdy_o && bus.wr_dst_rdy_i)
        rxq.push_back(mk(bus.wr_data_o, bus.wr_flags_o, bus.wr_occ_o));
      cyc++;
    end
    chk("timeout", 64'(cyc < 4000), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      bus.ll_src_rdy_i = 1'b0; bus.ll_sof_i = 1'b0; bus.ll_eof_i = 1'b0;
      bus.wr_dst_rdy_i = 1'b1;
      @(negedge clk);
      if (bus.wr_src_rdy_o && bus.wr_dst_rdy_i)
        rxq.push_back(mk(bus.wr_data_o, bus.wr_flags_o, bus.wr_occ_o));
    end
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " nwords"}, 64'(rxq.size()), 64'(expq.size()));
    n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s w%0d", tag, i), 64'(rxq[i]), 64'(expq[i]));
    chk({tag, " frame_cnt"}, 64'(frame_cnt), 64'(16'(exp_frames)));
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(16'(exp_err)));
  endtask

  task automatic clear_q();
    txq.delete(); rxq.delete(); expq.delete();
  endtask

  vec_t vt[6];

  initial begin
    int       acc, nfr, len;
    bit       rdy_end;
    vec_t     v;
    logic [7:0] b;

    vt[0] = '{14, 128'hFFFFFFFF_FFFF0011_22334455_08000000, 16'h0001, 16'h2000, 4,
              160'hFFFFFFFF_FFFF0011_22334455_08000000_00000000, 20'h10020,
              {3'd4, 3'd4, 3'd4, 3'd2, 3'd0}, 1, 0};
    vt[1] = '{4, 128'h010203AB_00000000_00000000_00000000, 16'h0008, 16'h0008, 1,
              160'hAB000000_00000000_00000000_00000000_00000000, 20'h30000,
              {3'd1, 12'd0}, 1, 3};
    vt[2] = '{6, 128'h11223334_35360000_00000000_00000000, 16'h0005, 16'h0020, 2,
              160'h11220000_33343536_00000000_00000000_00000000, 20'h63000,
              {3'd2, 3'd4, 9'd0}, 2, 1};
    vt[3] = '{5, 128'hA0A1A2A3_B0000000_00000000_00000000, 16'h0011, 16'h0010, 3,
              160'hA0A1A2A3_00000000_B0000000_00000000_00000000, 20'h16300,
              {3'd4, 3'd0, 3'd1, 6'd0}, 2, 1};
    vt[4] = '{5, 128'h01020304_05000000_00000000_00000000, 16'h0001, 16'h0010, 2,
              160'h01020304_05000000_00000000_00000000_00000000, 20'h12000,
              {3'd4, 3'd1, 9'd0}, 1, 0};
    vt[5] = '{4, 128'hC0C1C2C3_00000000_00000000_00000000, 16'h0001, 16'h0008, 1,
              160'hC0C1C2C3_00000000_00000000_00000000_00000000, 20'h30000,
              {3'd4, 12'd0}, 1, 0};

    // Reset state, with a byte offered so the ready gating by reset is visible.
    reset = 1'b1;
    bus.ll_src_rdy_i = 1'b1; bus.ll_data_i = 8'h5A; bus.ll_sof_i = 1'b1; bus.ll_eof_i = 1'b0;
    bus.wr_dst_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ll_dst_rdy", 64'(bus.ll_dst_rdy_o), 64'd0);
    chk("rst wr_src_rdy", 64'(bus.wr_src_rdy_o), 64'd0);
    chk("rst wr_data", 64'(bus.wr_data_o), 64'd0);
    chk("rst wr_flags", 64'(bus.wr_flags_o), 64'd0);
    chk("rst wr_occ", 64'(bus.wr_occ_o), 64'd0);
    chk("rst frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.ll_src_rdy_i = 1'b0;

    // 64-byte frame, no stalls.
    clear_q();
    for (int i = 0; i < 64; i++) txq.push_back('{8'(i), i == 0, i == 63});
    build_expected();
    run(0, 0, 0, acc, rdy_end);
    compare("f64");
    if (rxq.size() == 16) begin
      chk("f64 word0", 64'(rxq[0]), 64'(mk(32'h00010203, 4'h1, 3'd4)));
      chk("f64 word15", 64'(rxq[15]), 64'(mk(32'h3C3D3E3F, 4'h2, 3'd4)));
    end else begin
      chk("f64 size for word checks", 64'(rxq.size()), 64'd16);
    end

    // Directed table; expectations come from the table, not the model.
    for (int t = 0; t < 6; t++) begin
      clear_q();
      v = vt[t];
      for (int i = 0; i < v.nb; i++) begin
        b = v.d[127 - 8 * i -: 8];
        txq.push_back('{b, v.sof_m[i], v.eof_m[i]});
      end
      for (int j = 0; j < v.nw; j++)
        expq.push_back(mk(v.wd[159 - 32 * j -: 32], v.wf[19 - 4 * j -: 4], v.wo[14 - 3 * j -: 3]));
      exp_frames += v.dframe;
      exp_err    += v.derr;
      run(0, 0, 0, acc, rdy_end);
      compare($sformatf("vec%0d", t));
    end

    // Sink stalled for 40 clocks during a 32-byte frame.
    clear_q();
    for (int i = 0; i < 32; i++) txq.push_back('{8'(8'h40 + i), i == 0, i == 31});
    build_expected();
    run(0, 0, 40, acc, rdy_end);
    chk("stall bytes accepted", 64'(acc), 64'd8);
    chk("stall ll_dst_rdy", 64'(rdy_end), 64'd0);
    compare("stall");

    // Randomized streams: strays, aborts, gaps and stalls.
    for (int r = 0; r < 4; r++) begin
      clear_q();
      nfr = $urandom_range(6, 10);
      for (int f = 0; f < nfr; f++) begin
        if ($urandom_range(3) == 0)
          repeat ($urandom_range(1, 2)) txq.push_back('{8'($urandom), 1'b0, 1'($urandom)});
        if ($urandom_range(3) == 0) begin
          len = $urandom_range(1, 9);
          for (int i = 0; i < len; i++) txq.push_back('{8'($urandom), i == 0, 1'b0});
        end
        len = $urandom_range(1, 12);
        for (int i = 0; i < len; i++) txq.push_back('{8'($urandom), i == 0, i == len - 1});
      end
      build_expected();
      run(30, 30, 0, acc, rdy_end);
      compare($sformatf("rand%0d", r));
    end

    // Reset with two words buffered and a byte held at the input.
    clear_q();
    for (int i = 0; i < 12; i++) txq.push_back('{8'(8'h80 + i), i == 0, 1'b0});
    begin
      int bi;
      bi = 0;
      for (int c = 0; c < 14; c++) begin
        @(posedge clk); #1;
        bus.ll_src_rdy_i = 1'b1;
        bus.ll_data_i = txq[bi].d; bus.ll_sof_i = txq[bi].sof; bus.ll_eof_i = txq[bi].eof;
        bus.wr_dst_rdy_i = 1'b0;
        @(negedge clk);
        if (bus.ll_src_rdy_i && bus.ll_dst_rdy_o) bi++;
      end
      chk("prerst bytes accepted", 64'(bi), 64'd8);
      chk("prerst wr_src_rdy", 64'(bus.wr_src_rdy_o), 64'd1);
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.ll_src_rdy_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst wr_src_rdy", 64'(bus.wr_src_rdy_o), 64'd0);
    chk("midrst frame_cnt", 64'(frame_cnt), 64'd0);
    chk("midrst err_cnt", 64'(err_cnt), 64'd0);
    chk("midrst ll_dst_rdy", 64'(bus.ll_dst_rdy_o), 64'd1);
    exp_frames = 0; exp_err = 0;
    clear_q();
    for (int i = 0; i < 5; i++) txq.push_back('{8'(8'h01 + i), i == 0, i == 4});
    build_expected();
    run(0, 0, 0, acc, rdy_end);
    compare("postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eth_ll8_to_ll32.md
Name: eth_ll8_to_ll32

Overview:
- Receive-path packer between the Ethernet MAC's 8-bit LocalLink RX port and packet_receiver's 32-bit rd_* input.
- Packs bytes into 32-bit words, first byte in [31:24], and generates SOF/EOF/ERR flags.
- Buffers up to two completed words so the MAC is not stalled while packet_receiver holds rd_dst_rdy low.
- Counts frames and framing errors for status registers.

Parameters:
- CNT_W, 16, width of frame_cnt_o and err_cnt_o (both wrap).
- MSB_FIRST, 1: 1 = first byte of a word goes to [31:24]; 0 = first byte goes to [7:0].

Ports:
- clk  in  1  system clock, same clock as packet_receiver.
- reset  in  1  synchronous, active-high.
- ll_data_i  in  8  MAC RX byte.
- ll_sof_i  in  1  byte is first of frame.
- ll_eof_i  in  1  byte is last of frame.
- ll_src_rdy_i  in  1  byte valid.
- ll_dst_rdy_o  out  1  byte accepted when ll_src_rdy_i && ll_dst_rdy_o.
- wr_data_o  out  32  packed word; connects to rd_data_i.
- wr_flags_o  out  4  [0]=SOF, [1]=EOF, [2]=ERR (frame truncated), [3]=0; connects to rd_flags_i.
- wr_occ_o  out  3  valid bytes in word, 0..4; 4 except possibly on an EOF word.
- wr_src_rdy_o  out  1  word valid; connects to rd_src_rdy_i.
- wr_dst_rdy_i  in  1  word consumed when wr_src_rdy_o && wr_dst_rdy_i; connects to rd_dst_rdy_o.
- frame_cnt_o  out  CNT_W  EOF words emitted, including ERR words.
- err_cnt_o  out  CNT_W  count of stray bytes plus aborted frames.

Behaviour:
- Reset values: ll_dst_rdy_o=0 during reset; wr_src_rdy_o=0; wr_data_o=0; wr_flags_o=0; wr_occ_o=0; counters=0; FIFO empty; state IDLE; byte index=0.
- Reset mid-frame: the partial word and any buffered words are discarded; no EOF is emitted.
- Handshake:
  - ll_dst_rdy_o = !reset && (fifo_count < 2), combinational from the registered count.
  - wr_src_rdy_o = (fifo_count != 0).
  - wr_data/flags/occ are held stable while wr_src_rdy_o=1 && !wr_dst_rdy_i.
- Packing:
  - Accepted bytes shift into an assembly register; byte index 0..3.
  - A word is pushed in the same cycle as the byte that completes it: the 4th byte, or any byte with EOF.
  - The pushed word appears on wr_* the next cycle when the FIFO was empty (latency 1 clk from accepting the completing byte).
  - Unused low bytes of a short EOF word are 0.
  - SOF flag is set only on the first word of a frame.
- Simultaneous push and pop are allowed; the count is unchanged.
- States: IDLE, IN_FRAME.
  - IDLE + byte with SOF → IN_FRAME; the byte goes to index 0.
  - IDLE + byte with SOF && EOF → single word: occ=1, flags SOF|EOF; frame_cnt++; stay IDLE.
  - IDLE + byte without SOF → byte dropped; err_cnt++.
  - IN_FRAME + EOF byte → push word (occ = index+1), EOF set; frame_cnt++; → IDLE.
  - IN_FRAME + SOF byte (abort): first push a terminator for the old frame (held bytes, occ = bytes held, flags EOF|ERR; if 0 bytes held: data 0, occ 0). Then start the new frame with the SOF byte at index 0. err_cnt++, frame_cnt++.
    - A terminator and a completed new word never coincide, because the SOF byte alone cannot complete a word unless it also has EOF.
    - SOF+EOF abort case: push the terminator this cycle, latch the single-byte word in a pending slot, and push it next cycle with ll_dst_rdy_o forced low for that cycle.
- Counters wrap at 2^CNT_W.

Decomposition:
- Package eth_ll_pkg:
  - FLAG_SOF=0, FLAG_EOF=1, FLAG_ERR=2.
  - Word struct {data[31:0], flags[3:0], occ[2:0]}, 39 bits.
  - State enum IDLE/IN_FRAME.
- Sub-module ll_fifo2:
  - 2-entry, 39-bit, single-clock FIFO.
  - push/pop/count/head; sync active-high reset.
  - Reusable on the TX side.

Test Plan:
- 64-byte frame 0x00..0x3F, no stalls → 16 words. Word0=0x00010203 with flags 0x1; word15=0x3C3D3E3F with flags 0x2, occ=4. frame_cnt=1.
- 14-byte frame (ff ff ff ff ff ff 00 11 22 33 44 55 08 00) → words FFFFFFFF, FFFF0011, 22334455, 08000000. Last word has occ=2, EOF set.
- wr_dst_rdy_i held low for 40 clks during a 32-byte frame → ll_dst_rdy_o drops after the 2nd word is buffered and the 9th byte is held. No byte lost; output words are identical to the unstalled case.
- 3 bytes without SOF, then a 1-byte SOF+EOF frame 0xAB → err_cnt=3. Single word 0xAB000000 with flags 0x3, occ=1.
- SOF 0x11,0x22, then SOF 0x33..0x36 with EOF on 0x36 → terminator 0x11220000 with flags 0x6 (EOF|ERR), occ=2. Then 0x33343536 with flags 0x3. err_cnt=1, frame_cnt=2.
- reset asserted for 1 clk mid-frame with 2 words buffered → next cycle wr_src_rdy_o=0, counters 0. A following frame packs from index 0.
